// File: rtl/hier_icache_pkg.sv
// Shared types and register map for the hierarchical icache control block.
package hier_icache_pkg;

  localparam logic [5:0] ICACHE_ENABLE_OFF      = 6'h00;
  localparam logic [5:0] ICACHE_FLUSH_OFF       = 6'h01;
  localparam logic [5:0] ICACHE_FLUSH_L1_OFF    = 6'h02;
  localparam logic [5:0] ICACHE_SEL_FLUSH_OFF   = 6'h03;
  localparam logic [5:0] ICACHE_CLEAR_CNTS_OFF  = 6'h04;
  localparam logic [5:0] ICACHE_ENABLE_CNTS_OFF = 6'h05;
  localparam logic [5:0] ICACHE_PREFETCH_OFF    = 6'h07;

  localparam logic [1:0] INIT_LAST_STEP = 2'd2;

  typedef enum logic [2:0] {
    OP_ENABLE        = 3'd0,
    OP_FLUSH         = 3'd1,
    OP_FLUSH_L1_ONLY = 3'd2,
    OP_SEL_FLUSH     = 3'd3,
    OP_CLEAR_CNTS    = 3'd4,
    OP_ENABLE_CNTS   = 3'd5,
    OP_PREFETCH_EN   = 3'd6,
    OP_INIT          = 3'd7
  } icache_cfg_op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    NEXT     = 3'd3,
    DONE     = 3'd4
  } icache_cfg_state_e;

  function automatic logic [5:0] icache_cfg_offset(input icache_cfg_op_e op,
                                                   input logic [1:0] step);
    logic [5:0] off;
    off = ICACHE_ENABLE_OFF;
    case (op)
      OP_ENABLE:        off = ICACHE_ENABLE_OFF;
      OP_FLUSH:         off = ICACHE_FLUSH_OFF;
      OP_FLUSH_L1_ONLY: off = ICACHE_FLUSH_L1_OFF;
      OP_SEL_FLUSH:     off = ICACHE_SEL_FLUSH_OFF;
      OP_CLEAR_CNTS:    off = ICACHE_CLEAR_CNTS_OFF;
      OP_ENABLE_CNTS:   off = ICACHE_ENABLE_CNTS_OFF;
      OP_PREFETCH_EN:   off = ICACHE_PREFETCH_OFF;
      OP_INIT: begin
        // INIT = enable, full flush, enable counters
        case (step)
          2'd0:    off = ICACHE_ENABLE_OFF;
          2'd1:    off = ICACHE_FLUSH_OFF;
          default: off = ICACHE_ENABLE_CNTS_OFF;
        endcase
      end
      default:          off = ICACHE_ENABLE_OFF;
    endcase
    return off;
  endfunction

  function automatic logic [31:0] icache_cfg_wdata(input icache_cfg_op_e op,
                                                   input logic [1:0] step,
                                                   input logic [31:0] data);
    logic [31:0] wd;
    wd = 32'h0;
    case (op)
      OP_ENABLE, OP_SEL_FLUSH, OP_ENABLE_CNTS, OP_PREFETCH_EN: wd = data;
      OP_INIT:  wd = (step == 2'd1) ? 32'h0 : 32'h1;
      default:  wd = 32'h0;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/icache_cfg_initiator.sv
// Turns one abstract icache command into register writes on the peripheral bus.
// Define ICACHE_CFG_TIMEOUT_EN to build the per-transaction timeout counter and abort path.
//
// state    | meaning
// IDLE     | ready for a command
// REQ      | req_o high, waiting for gnt_i
// WAIT_RSP | granted, waiting for r_valid_i
// NEXT     | gap cycle before the next INIT step
// DONE     | one-cycle completion pulse
module icache_cfg_initiator
  import hier_icache_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h1A10_C000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [2:0]  cmd_op_i,
  input  logic [31:0] cmd_data_i,
  output logic        busy_o,
  output logic        done_valid_o,
  output logic        done_err_o,
  output logic        done_timeout_o,
  output logic        req_o,
  output logic [31:0] addr_o,
  output logic        wen_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  input  logic        gnt_i,
  input  logic        r_valid_i,
  input  logic        r_opc_i
);

  icache_cfg_state_e state_q, state_d;
  icache_cfg_op_e    op_q, op_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        step_q, step_d;
  logic              req_q, req_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rdy_q, rdy_d;
  logic              busy_q, busy_d;
  logic              done_valid_q, done_valid_d;
  logic              done_err_q, done_err_d;
  logic              done_to_q, done_to_d;
  logic              to_expire;
  logic              err_hit;
  logic              to_hit;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    data_d  = data_q;
    step_d  = step_q;
    err_hit = 1'b0;
    to_hit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          state_d = REQ;
          op_d    = icache_cfg_op_e'(cmd_op_i);
          data_d  = cmd_data_i;
          step_d  = 2'd0;
        end
      end
      REQ: begin
        if (to_expire) begin
          to_hit  = 1'b1;
          state_d = DONE;
        end else if (gnt_i) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (to_expire) begin
          to_hit  = 1'b1;
          state_d = DONE;
        end else if (r_valid_i) begin
          if (r_opc_i) begin
            err_hit = 1'b1;
            state_d = DONE;
          end else if ((op_q == OP_INIT) && (step_q != INIT_LAST_STEP)) begin
            state_d = NEXT;
            step_d  = step_q + 2'd1;
          end else begin
            state_d = DONE;
          end
        end
      end
      NEXT:    state_d = REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    req_d        = (state_d == REQ);
    rdy_d        = (state_d == IDLE);
    busy_d       = (state_d != IDLE);
    done_valid_d = (state_d == DONE);
    done_err_d   = err_hit;
    done_to_d    = to_hit;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if (state_d == REQ) begin
      addr_d  = BASE_ADDR + {24'h0, icache_cfg_offset(op_d, step_d), 2'b00};
      wdata_d = icache_cfg_wdata(op_d, step_d, data_d);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      op_q         <= OP_ENABLE;
      data_q       <= 32'h0;
      step_q       <= 2'd0;
      req_q        <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rdy_q        <= 1'b1;
      busy_q       <= 1'b0;
      done_valid_q <= 1'b0;
      done_err_q   <= 1'b0;
      done_to_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      data_q       <= data_d;
      step_q       <= step_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdy_q        <= rdy_d;
      busy_q       <= busy_d;
      done_valid_q <= done_valid_d;
      done_err_q   <= done_err_d;
      done_to_q    <= done_to_d;
    end
  end

`ifdef ICACHE_CFG_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == REQ) || (state_q == WAIT_RSP)) cnt_d = cnt_q + 1'b1;
    if ((state_d == REQ) && (state_q != REQ)) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Expiry wins over a grant or response arriving in the same cycle.
  assign to_expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // No counter: never expires for any legal TIMEOUT_CYCLES (>= 2).
  assign to_expire = (TIMEOUT_CYCLES < 2);
`endif

  assign cmd_ready_o    = rdy_q;
  assign busy_o         = busy_q;
  assign done_valid_o   = done_valid_q;
  assign done_err_o     = done_err_q;
  assign done_timeout_o = done_to_q;
  assign req_o          = req_q;
  assign addr_o         = addr_q;
  assign wdata_o        = wdata_q;
  assign wen_o          = 1'b0;
  assign be_o           = 4'hF;

endmodule
